// File: rtl/icache_axi_refill.sv
// AXI4 read master that refills one instruction-cache line per miss.
// One INCR burst per miss; the assembled line is returned with a one-cycle valid pulse.
module icache_axi_refill #(
    parameter int          LINE_BEATS = 4,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       miss_req,
    input  logic [31:0]                miss_addr,
    output logic                       miss_ack,
    output logic                       refill_valid,
    output logic [31:0]                refill_addr,
    output logic [LINE_BEATS*64-1:0]   refill_data,
    output logic                       refill_err,
    output logic [31:0]                m_araddr,
    output logic [1:0]                 m_arburst,
    output logic [7:0]                 m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [3:0]                 m_arid,
    output logic [3:0]                 m_arcache,
    output logic [2:0]                 m_arprot,
    output logic                       m_arlock,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [63:0]                m_rdata,
    input  logic [3:0]                 m_rid,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready
);

    localparam int          CW       = $clog2(LINE_BEATS) + 1;
    localparam int          IW       = CW - 1;
    localparam logic [31:0] OFF_MASK = 32'(LINE_BEATS * 8 - 1);
    localparam logic [CW-1:0] LB_C   = CW'(LINE_BEATS);
    localparam logic [CW-1:0] LAST_C = CW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {IDLE, AREQ, RDATA, DONE} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [31:0]               raddr_q, raddr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [LINE_BEATS*64-1:0]  line_q, line_d;
    logic                      unused_rresp;

    assign unused_rresp = m_rresp[0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        raddr_d      = raddr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        line_d       = line_q;
        miss_ack     = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        refill_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                miss_ack = 1'b1;
                if (miss_req) begin
                    addr_d  = miss_addr & ~OFF_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = AREQ;
                end
            end
            AREQ: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = RDATA;
            end
            RDATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    // Beats past the line end are dropped; the count saturates.
                    if (cnt_q < LB_C) begin
                        line_d[int'(cnt_q[IW-1:0]) * 64 +: 64] = m_rdata;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (m_rresp[1] || (m_rid != AXI_ID) ||
                        (m_rlast && (cnt_q != LAST_C)) ||
                        (cnt_q >= LB_C))
                        err_d = 1'b1;
                    if (m_rlast) begin
                        raddr_d = addr_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                refill_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            raddr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            line_q  <= line_d;
        end
    end

    assign refill_err  = (state_q == DONE) & err_q;
    assign refill_addr = raddr_q;
    assign refill_data = line_q;
    assign m_araddr    = addr_q;
    assign m_arburst   = 2'b01;
    assign m_arlen     = 8'(LINE_BEATS - 1);
    assign m_arsize    = 3'b011;
    assign m_arid      = AXI_ID;
    assign m_arcache   = 4'h0;
    assign m_arprot    = 3'h0;
    assign m_arlock    = 1'b0;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Randomized bench for icache_axi_refill: an AXI slave model feeds bursts and a
// line-level reference (expected line, address and error) judges each refill.
module tb_icache_axi_refill;

    localparam int LB = 4;
    localparam int LW = LB * 64;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          miss_ack;
    logic          refill_valid;
    logic [31:0]   refill_addr;
    logic [LW-1:0] refill_data;
    logic          refill_err;
    logic [31:0]   m_araddr;
    logic [1:0]    m_arburst;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [3:0]    m_arid;
    logic [3:0]    m_arcache;
    logic [2:0]    m_arprot;
    logic          m_arlock;
    logic          m_arvalid;
    logic          m_arready;
    logic [63:0]   m_rdata;
    logic [3:0]    m_rid;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;

    int            errs   = 0;
    int            checks = 0;
    logic [LW-1:0] exp_line = '0;

    always #5 aclk = ~aclk;

    icache_axi_refill #(.LINE_BEATS(LB), .AXI_ID(4'h0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .refill_valid(refill_valid), .refill_addr(refill_addr),
        .refill_data(refill_data), .refill_err(refill_err),
        .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arid(m_arid), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arlock(m_arlock), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_ack"},    miss_ack, 1);
        chk({tag, "_arv"},    m_arvalid, 0);
        chk({tag, "_rrdy"},   m_rready, 0);
        chk({tag, "_rv"},     refill_valid, 0);
        chk({tag, "_rerr"},   refill_err, 0);
        chk({tag, "_raddr"},  refill_addr, 0);
        chk({tag, "_rdata"},  refill_data, 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the DONE cycle
    // (or right after an injected reset when rst_at >= 0).
    task automatic do_refill(input logic [31:0] a, input int ard,
                             input int nb, input int badk, input int badi,
                             input int rst_at);
        logic [31:0]   la;
        logic [LW-1:0] line;
        logic [63:0]   d;
        logic [1:0]    resp;
        logic [3:0]    id;
        logic          err, ar_bad, busy_bad, seen_rv;
        int            gap;
        la = a & ~32'(LB * 8 - 1);
        chk("ack_idle", miss_ack, 1);
        miss_req  = 1'b1;
        miss_addr = a;
        @(negedge aclk);
        miss_req  = 1'b0;
        miss_addr = $urandom;
        ar_bad    = 1'b0;
        busy_bad  = 1'b0;
        for (int k = 0; k <= ard; k++) begin
            if (m_arvalid !== 1'b1 || m_araddr !== la) ar_bad = 1'b1;
            if (miss_ack !== 1'b0 || m_rready !== 1'b0) busy_bad = 1'b1;
            if (k == ard) begin
                chk("araddr",  m_araddr, la);
                chk("arlen",   m_arlen, LB - 1);
                chk("arburst", m_arburst, 1);
                chk("arsize",  m_arsize, 3);
                chk("arid",    m_arid, 0);
                chk("ar_zero", {m_arcache, m_arprot, m_arlock}, 0);
            end
            m_arready = (k == ard);
            @(negedge aclk);
        end
        m_arready = 1'b0;
        chk("ar_stable", ar_bad, 0);
        err     = (nb != LB);
        line    = exp_line;
        seen_rv = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i == rst_at) begin
                aresetn  = 1'b0;
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                #1;
                reset_vals("rst_mid");
                exp_line = '0;
                @(negedge aclk);
                aresetn = 1'b1;
                repeat (4) begin
                    @(negedge aclk);
                    if (refill_valid !== 1'b0) seen_rv = 1'b1;
                end
                chk("rst_no_pulse", seen_rv, 0);
                return;
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                m_rvalid = 1'b0;
                if (m_rready !== 1'b1 || miss_ack !== 1'b0 ||
                    m_arvalid !== 1'b0 || refill_valid !== 1'b0)
                    busy_bad = 1'b1;
                @(negedge aclk);
            end
            if (m_rready !== 1'b1 || miss_ack !== 1'b0 ||
                m_arvalid !== 1'b0 || refill_valid !== 1'b0)
                busy_bad = 1'b1;
            d    = {$urandom, $urandom};
            resp = (badk == 1 && i == badi) ? {1'b1, 1'($urandom_range(0, 1))}
                                             : {1'b0, 1'($urandom_range(0, 1))};
            id   = (badk == 2 && i == badi) ? 4'($urandom_range(1, 15)) : 4'h0;
            m_rvalid = 1'b1;
            m_rdata  = d;
            m_rresp  = resp;
            m_rid    = id;
            m_rlast  = (i == nb - 1);
            if (resp[1] || id != 4'h0) err = 1'b1;
            if (i < LB) line[i*64 +: 64] = d;
            @(negedge aclk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("busy_ok", busy_bad, 0);
        chk("rv_pulse", refill_valid, 1);
        chk("raddr", refill_addr, la);
        chk("rerr", refill_err, err);
        chk("rdata", refill_data, line);
        exp_line = line;
    endtask

    task automatic end_pulse();
        @(negedge aclk);
        chk("rv_one", refill_valid, 0);
        chk("ack_back", miss_ack, 1);
    endtask

    initial begin
        int ard, nb, badk, sel;
        aresetn   = 1'b0;
        miss_req  = 1'b0;
        miss_addr = '0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rid     = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        repeat (2) @(negedge aclk);
        reset_vals("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        do_refill(32'h1000_0014, 0, LB, 0, 0, -1);
        end_pulse();
        do_refill(32'h2000_0008, 5, LB, 0, 0, -1);
        end_pulse();
        do_refill(32'h3000_0030, 0, LB, 1, 2, -1);
        end_pulse();
        do_refill(32'h3000_0100, 1, 2, 0, 0, -1);
        end_pulse();
        do_refill(32'h4000_0000, 0, LB, 0, 0, 2);
        do_refill(32'h4000_0020, 0, LB, 0, 0, -1);
        end_pulse();

        do_refill(32'h0000_0040, 0, LB, 0, 0, -1);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0080;
        chk("ack_in_done", miss_ack, 0);
        @(negedge aclk);
        chk("rv_one_b2b", refill_valid, 0);
        do_refill(32'h0000_0080, 0, LB, 0, 0, -1);
        end_pulse();

        for (int n = 0; n < 25; n++) begin
            ard  = $urandom_range(0, 4);
            sel  = $urandom_range(0, 9);
            nb   = (sel < 6) ? LB :
                   (sel < 8) ? $urandom_range(1, LB - 1) : LB + $urandom_range(1, 2);
            badk = $urandom_range(0, 4);
            if (badk > 2) badk = 0;
            do_refill($urandom, ard, nb, badk, $urandom_range(0, LB - 1), -1);
            end_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
